// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM operand loader: FSM encoding,
// read-data phase tags and lane/word geometry functions.
package cim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_IN,
    ST_LOAD_WT,
    ST_WAIT_LAST,
    ST_PRESENT
  } state_e;

  localparam logic PH_IN = 1'b0;
  localparam logic PH_WT = 1'b1;

  function automatic int lanes_f(input int sram_w, input int data_w);
    return sram_w / data_w;
  endfunction

  function automatic int words_f(input int vec_len, input int lanes);
    return vec_len / lanes;
  endfunction

  function automatic int idx_w_f(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cim_lane_scatter.sv
// Registered vector buffer: each write deposits one SRAM word into LANES
// consecutive lanes starting at lane wr_idx*LANES.
module cim_lane_scatter
  import cim_pkg::*;
#(
  parameter int VEC_LEN         = 256,
  parameter int DATA_WIDTH      = 8,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int IDX_W           = idx_w_f(words_f(VEC_LEN, lanes_f(SRAM_DATA_WIDTH, DATA_WIDTH)))
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [SRAM_DATA_WIDTH-1:0]    wr_data,
  output logic [VEC_LEN*DATA_WIDTH-1:0] vec
);

  localparam int LANES = lanes_f(SRAM_DATA_WIDTH, DATA_WIDTH);

  logic [VEC_LEN*DATA_WIDTH-1:0] vec_q, vec_d;

  always_comb begin
    vec_d = vec_q;
    if (wr_en) begin
      for (int j = 0; j < LANES; j++) begin
        vec_d[(int'(wr_idx) * LANES + j) * DATA_WIDTH +: DATA_WIDTH] =
          wr_data[j * DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vec_q <= '0;
    else        vec_q <= vec_d;
  end

  assign vec = vec_q;

endmodule

// File: rtl/cim_operand_loader.sv
// Streams one input and one weight vector out of SRAM port B, unpacks the
// words into lanes and presents both vectors under valid/ready.
module cim_operand_loader
  import cim_pkg::*;
#(
  parameter int VEC_LEN         = 256,
  parameter int DATA_WIDTH      = 8,
  parameter int SRAM_ADDR_WIDTH = 17,
  parameter int SRAM_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SRAM_ADDR_WIDTH-1:0]    in_base,
  input  logic [SRAM_ADDR_WIDTH-1:0]    wt_base,
  output logic                          busy,
  output logic                          done,
  output logic [SRAM_ADDR_WIDTH-1:0]    sram_addr_b,
  output logic                          sram_en_b,
  input  logic [SRAM_DATA_WIDTH-1:0]    sram_rdata_b,
  output logic [VEC_LEN*DATA_WIDTH-1:0] vec_input,
  output logic [VEC_LEN*DATA_WIDTH-1:0] vec_weight,
  output logic                          vec_valid,
  input  logic                          vec_ready
);

  localparam int LANES = lanes_f(SRAM_DATA_WIDTH, DATA_WIDTH);
  localparam int WORDS = words_f(VEC_LEN, LANES);
  localparam int IDX_W = idx_w_f(WORDS);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(WORDS - 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           k_q, k_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SRAM_ADDR_WIDTH-1:0] wt_base_q, wt_base_d;
  logic                       en_q, en_d;
  logic                       busy_q, busy_d;
  logic                       valid_q, valid_d;
  logic                       rd_vld_q, rd_vld_d;
  logic                       rd_ph_q, rd_ph_d;
  logic [IDX_W-1:0]           rd_idx_q, rd_idx_d;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    addr_d    = addr_q;
    wt_base_d = wt_base_q;
    en_d      = en_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    // Tag pipeline: describes the word that returns on rdata next cycle.
    rd_vld_d  = en_q;
    rd_ph_d   = (state_q == ST_LOAD_WT) ? PH_WT : PH_IN;
    rd_idx_d  = k_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD_IN;
          addr_d    = in_base;
          wt_base_d = wt_base;
          en_d      = 1'b1;
          k_d       = '0;
          busy_d    = 1'b1;
        end
      end
      ST_LOAD_IN: begin
        k_d    = k_q + 1'b1;
        addr_d = addr_q + 1'b1;
        if (k_q == LAST_K) begin
          state_d = ST_LOAD_WT;
          addr_d  = wt_base_q;
          k_d     = '0;
        end
      end
      ST_LOAD_WT: begin
        k_d    = k_q + 1'b1;
        addr_d = addr_q + 1'b1;
        if (k_q == LAST_K) begin
          state_d = ST_WAIT_LAST;
          addr_d  = addr_q;
          en_d    = 1'b0;
          k_d     = '0;
        end
      end
      ST_WAIT_LAST: begin
        state_d = ST_PRESENT;
        valid_d = 1'b1;
      end
      ST_PRESENT: begin
        if (vec_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      addr_q    <= '0;
      wt_base_q <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_ph_q   <= PH_IN;
      rd_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      wt_base_q <= wt_base_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      rd_vld_q  <= rd_vld_d;
      rd_ph_q   <= rd_ph_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  cim_lane_scatter #(
    .VEC_LEN(VEC_LEN), .DATA_WIDTH(DATA_WIDTH),
    .SRAM_DATA_WIDTH(SRAM_DATA_WIDTH), .IDX_W(IDX_W)
  ) u_scatter_in (
    .clk(clk), .rst_n(rst_n),
    .wr_en(rd_vld_q && (rd_ph_q == PH_IN)),
    .wr_idx(rd_idx_q), .wr_data(sram_rdata_b), .vec(vec_input)
  );

  cim_lane_scatter #(
    .VEC_LEN(VEC_LEN), .DATA_WIDTH(DATA_WIDTH),
    .SRAM_DATA_WIDTH(SRAM_DATA_WIDTH), .IDX_W(IDX_W)
  ) u_scatter_wt (
    .clk(clk), .rst_n(rst_n),
    .wr_en(rd_vld_q && (rd_ph_q == PH_WT)),
    .wr_idx(rd_idx_q), .wr_data(sram_rdata_b), .vec(vec_weight)
  );

  assign busy        = busy_q;
  assign done        = valid_q & vec_ready;
  assign sram_addr_b = addr_q;
  assign sram_en_b   = en_q;
  assign vec_valid   = valid_q;

endmodule
